// File: rtl/mealy_1101_detector.sv
// Mealy detector for the serial pattern 1-1-0-1, with optional overlapping detection.
// Defining MEALY_1101_DETECTOR_COUNT_EN adds a saturating match counter on match_count.
module mealy_1101_detector #(
    parameter int OVERLAP = 1,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             x,
    output logic             y
`ifdef MEALY_1101_DETECTOR_COUNT_EN
    ,
    output logic [CNT_W-1:0] match_count
`endif
);

    typedef enum logic [1:0] {
        S0   = 2'b00,
        S1   = 2'b01,
        S11  = 2'b10,
        S110 = 2'b11
    } state_e;

    state_e state_q, state_d;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its peers, independent of block order.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S0;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output of this block gets a default first; a path that left
    // one unassigned would infer a latch.
    always_comb begin
        state_d = S0;
        y       = 1'b0;
        case (state_q)
            S0:      state_d = x ? S1 : S0;
            S1:      state_d = x ? S11 : S0;
            S11:     state_d = x ? S11 : S110;
            S110: begin
                if (x) begin
                    y       = reset_n;
                    state_d = (OVERLAP != 0) ? S1 : S0;
                end else begin
                    state_d = S0;
                end
            end
            default: state_d = S0;
        endcase
    end

`ifdef MEALY_1101_DETECTOR_COUNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // y already carries the reset_n qualification, so reset cycles never count.
    always_comb begin
        cnt_d = cnt_q;
        if (y && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign match_count = cnt_q;
`endif

endmodule

// File: tb/tb_mealy_1101_detector.sv
// Randomized and directed bench for mealy_1101_detector, overlapping and non-overlapping
// instances side by side; the counter is exercised when MEALY_1101_DETECTOR_COUNT_EN is set.
module tb_mealy_1101_detector;

    localparam int TB_CNT_W = 2;
    localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;

    logic clk = 1'b0;
    logic reset_n;
    logic x;
    logic y_ov;
    logic y_no;
`ifdef MEALY_1101_DETECTOR_COUNT_EN
    logic [TB_CNT_W-1:0] cnt_ov;
    logic [TB_CNT_W-1:0] cnt_no;
`endif

    int errors = 0;
    int checks = 0;

    // Reference model: the bits seen since the detector last restarted.
    // A match is simply "the last four such bits, including the present one, are 1101".
    logic [3:0] win_ov, win_no;
    int         len_ov, len_no;
    int         exp_cnt_ov, exp_cnt_no;

    always #5 clk = ~clk;

    mealy_1101_detector #(.OVERLAP(1), .CNT_W(TB_CNT_W)) dut_ov (
        .clk        (clk),
        .reset_n    (reset_n),
        .x          (x),
        .y          (y_ov)
`ifdef MEALY_1101_DETECTOR_COUNT_EN
        ,
        .match_count(cnt_ov)
`endif
    );

    mealy_1101_detector #(.OVERLAP(0), .CNT_W(TB_CNT_W)) dut_no (
        .clk        (clk),
        .reset_n    (reset_n),
        .x          (x),
        .y          (y_no)
`ifdef MEALY_1101_DETECTOR_COUNT_EN
        ,
        .match_count(cnt_no)
`endif
    );

    function automatic logic model_hit(input logic [3:0] win, input int len, input logic xb);
        return (len >= 3) && ({win[2:0], xb} == 4'b1101);
    endfunction

    function automatic logic model_y_ov(input logic xb, input logic rb);
        return rb && model_hit(win_ov, len_ov, xb);
    endfunction

    function automatic logic model_y_no(input logic xb, input logic rb);
        return rb && model_hit(win_no, len_no, xb);
    endfunction

    // Advance the model across one rising edge.
    task automatic model_update(input logic xb, input logic rb);
        logic hit_ov, hit_no;
        hit_ov = model_y_ov(xb, rb);
        hit_no = model_y_no(xb, rb);
        if (!rb) begin
            win_ov = '0; len_ov = 0; exp_cnt_ov = 0;
            win_no = '0; len_no = 0; exp_cnt_no = 0;
        end else begin
            win_ov = {win_ov[2:0], xb};
            len_ov = len_ov + 1;
            if (hit_no) begin
                win_no = '0;
                len_no = 0;
            end else begin
                win_no = {win_no[2:0], xb};
                len_no = len_no + 1;
            end
            if (hit_ov && exp_cnt_ov < CNT_MAX) exp_cnt_ov = exp_cnt_ov + 1;
            if (hit_no && exp_cnt_no < CNT_MAX) exp_cnt_no = exp_cnt_no + 1;
        end
    endtask

    // One cycle: drive after the falling edge, compare mid-low-phase, then cross the rising edge.
    task automatic step(input logic xb, input logic rb, output logic got_ov, output logic got_no);
        logic e_ov, e_no;
        @(negedge clk);
        x       = xb;
        reset_n = rb;
        #1;
        e_ov = model_y_ov(xb, rb);
        e_no = model_y_no(xb, rb);
        checks++;
        if (y_ov !== e_ov) begin
            errors++;
            $display("FAIL y_overlap t=%0t x=%0b rst_n=%0b got=%0b exp=%0b", $time, xb, rb, y_ov, e_ov);
        end
        checks++;
        if (y_no !== e_no) begin
            errors++;
            $display("FAIL y_nonoverlap t=%0t x=%0b rst_n=%0b got=%0b exp=%0b", $time, xb, rb, y_no, e_no);
        end
`ifdef MEALY_1101_DETECTOR_COUNT_EN
        checks++;
        if (cnt_ov !== TB_CNT_W'(exp_cnt_ov) || cnt_no !== TB_CNT_W'(exp_cnt_no)) begin
            errors++;
            $display("FAIL match_count t=%0t got=%0d/%0d exp=%0d/%0d", $time, cnt_ov, cnt_no,
                     exp_cnt_ov, exp_cnt_no);
        end
`endif
        got_ov = y_ov;
        got_no = y_no;
        @(posedge clk);
        model_update(xb, rb);
    endtask

    task automatic do_reset();
        logic g0, g1;
        step(1'b0, 1'b0, g0, g1);
        step(1'b1, 1'b0, g0, g1);
    endtask

    // Drive n bits (msb first) and hold the strobes against hand-written expectations.
    task automatic run_seq(input string name, input logic [15:0] bits, input int n,
                           input logic [15:0] exp_ov, input logic [15:0] exp_no);
        logic [15:0] got_ov_v, got_no_v;
        logic        g0, g1;
        got_ov_v = '0;
        got_no_v = '0;
        for (int i = n - 1; i >= 0; i--) begin
            step(bits[i], 1'b1, g0, g1);
            got_ov_v[i] = g0;
            got_no_v[i] = g1;
        end
        checks++;
        if (got_ov_v !== exp_ov || got_no_v !== exp_no) begin
            errors++;
            $display("FAIL seq_%s got ov=%b no=%b exp ov=%b no=%b", name, got_ov_v, got_no_v,
                     exp_ov, exp_no);
        end
    endtask

    task automatic test_reset();
        logic g0, g1;
        do_reset();
        step(1'b1, 1'b0, g0, g1);
        checks++;
        if (g0 !== 1'b0 || g1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_y got=%0b%0b exp=00", g0, g1);
        end
    endtask

    task automatic test_basic();
        do_reset();
        run_seq("011101", 16'b011101, 6, 16'b000001, 16'b000001);
        // Overlapping instance now sits in S1, so 1,0,1 completes another match.
        run_seq("after_match_101", 16'b101, 3, 16'b001, 16'b000);
    endtask

    task automatic test_back_to_back();
        do_reset();
        run_seq("1101101", 16'b1101101, 7, 16'b0001001, 16'b0001000);
    endtask

    task automatic test_no_match();
        do_reset();
        run_seq("1011001", 16'b1011001, 7, 16'b0000000, 16'b0000000);
        do_reset();
        run_seq("111101", 16'b111101, 6, 16'b000001, 16'b000001);
    endtask

    task automatic test_reset_mid_sequence();
        logic g0, g1;
        do_reset();
        run_seq("prefix_11", 16'b11, 2, 16'b00, 16'b00);
        step(1'b1, 1'b0, g0, g1);
        run_seq("restart_1101", 16'b1101, 4, 16'b0001, 16'b0001);
        do_reset();
        run_seq("prefix_110", 16'b110, 3, 16'b000, 16'b000);
        step(1'b1, 1'b0, g0, g1);
        checks++;
        if (g0 !== 1'b0 || g1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_s110 got=%0b%0b exp=00", g0, g1);
        end
        run_seq("after_s110_reset", 16'b101, 3, 16'b000, 16'b000);
    endtask

    task automatic test_mid_cycle_toggle();
        do_reset();
        run_seq("to_s110", 16'b110, 3, 16'b000, 16'b000);
        @(negedge clk);
        reset_n = 1'b1;
        x       = 1'b0;
        #1;
        checks++;
        if (y_ov !== 1'b0 || y_no !== 1'b0) begin
            errors++;
            $display("FAIL toggle_low got=%0b%0b exp=00", y_ov, y_no);
        end
        #1;
        x = 1'b1;
        #1;
        checks++;
        if (y_ov !== 1'b1 || y_no !== 1'b1) begin
            errors++;
            $display("FAIL toggle_high got=%0b%0b exp=11", y_ov, y_no);
        end
        @(posedge clk);
        model_update(1'b1, 1'b1);
    endtask

`ifdef MEALY_1101_DETECTOR_COUNT_EN
    task automatic test_counter();
        logic [15:0] bits;
        int          exp_seq[4];
        int          k;
        logic        g0, g1;
        bits    = 16'b1101101101101;
        exp_seq = '{1, 2, 3, 3};
        k       = 0;
        do_reset();
        for (int i = 12; i >= 0; i--) begin
            step(bits[i], 1'b1, g0, g1);
            if (g0) begin
                #1;
                checks++;
                if (k > 3 || cnt_ov !== TB_CNT_W'(exp_seq[k])) begin
                    errors++;
                    $display("FAIL count_sat match=%0d got=%0d", k, cnt_ov);
                end
                k++;
            end
        end
        checks++;
        if (k != 4) begin
            errors++;
            $display("FAIL count_matches got=%0d exp=4", k);
        end
        step(1'b0, 1'b0, g0, g1);
        #1;
        checks++;
        if (cnt_ov !== '0 || cnt_no !== '0) begin
            errors++;
            $display("FAIL count_reset got=%0d/%0d exp=0", cnt_ov, cnt_no);
        end
    endtask
`endif

    task automatic test_random();
        logic g0, g1;
        logic xb, rb;
        for (int i = 0; i < 400; i++) begin
            xb = ($urandom_range(0, 99) < 60);
            rb = ($urandom_range(0, 99) >= 3);
            step(xb, rb, g0, g1);
        end
    endtask

    initial begin
        x       = 1'b0;
        reset_n = 1'b0;
        win_ov = '0; len_ov = 0; exp_cnt_ov = 0;
        win_no = '0; len_no = 0; exp_cnt_no = 0;
        repeat (2) @(posedge clk);

        test_reset();
        test_basic();
        test_back_to_back();
        test_no_match();
        test_reset_mid_sequence();
        test_mid_cycle_toggle();
`ifdef MEALY_1101_DETECTOR_COUNT_EN
        test_counter();
`endif
        test_random();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mealy_1101_detector.md
# mealy_1101_detector

Serial bit-stream pattern detector that asserts `y` combinationally (Mealy style) in the same cycle the final bit of the sequence 1-1-0-1 is present on `x`. It is a small FSM sitting on a one-bit serial data path and feeds single-cycle match strobes to downstream control logic. Overlapping detection is the default, so the trailing `1` of one match may start the next. An optional saturating match counter can be compiled in.

## Interface
Parameters:
- `OVERLAP`, default 1, 1 = overlapping detection; 0 = non-overlapping (restart from idle after a match).
- `CNT_W`, default 8, width of optional match counter (only used when `MEALY_1101_DETECTOR_COUNT_EN` is defined).

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `reset_n`  input  1  reset; synchronous and active-low.
- `x`  input  1  serial data bit, sampled every rising edge.
- `y`  output  1  Mealy match strobe; combinational from current state and `x`.
- `match_count`  output  CNT_W  number of matches since reset; present only with `MEALY_1101_DETECTOR_COUNT_EN`.

## Operation
- States (2-bit encoding): S0 = no progress, S1 = "1" seen, S11 = "11" seen, S110 = "110" seen.
- Transitions (x=0 / x=1):
  - S0: S0 / S1
  - S1: S0 / S11
  - S11: S110 / S11 (extra 1s keep the "11" prefix)
  - S110: S0 / S1 if `OVERLAP`=1, S0 if `OVERLAP`=0
- Output: `y` = 1 exactly when state == S110 and `x` == 1 and `reset_n` == 1; otherwise 0.
- `y` is combinational: it changes with `x` mid-cycle and is not registered.
- Illegal/unreachable encodings return to S0 on the next edge with `y` = 0.

## Timing
- Reset: on a rising edge with `reset_n` = 0, state <= S0 (and `match_count` <= 0). While `reset_n` = 0, `y` is forced to 0 regardless of state or `x`.
- Reset is synchronous only: deasserting/asserting `reset_n` between edges has no effect on state until the next rising edge.
- Reset mid-sequence (e.g. in S11) discards all progress; detection restarts from S0 on the first edge with `reset_n` = 1.
- Latency: zero cycles from the fourth pattern bit on `x` to `y` = 1 (same cycle, before the edge that consumes it).
- `y` is high for at most one cycle per match when `x` is held stable per cycle; back-to-back matches are separated by at least 3 cycles with `OVERLAP`=1 (1101101 yields two strobes).
- Without `OVERLAP`, minimum spacing is 4 cycles.

## Configuration
- `MEALY_1101_DETECTOR_COUNT_EN` defined: adds `match_count`, incremented on each rising edge where `y` = 1 (and `reset_n` = 1), saturating at all-ones, cleared by synchronous reset.
- Not defined: no counter logic and no `match_count` port; behaviour of `y` is identical.

## Test plan
- Reset then 0,1,1,1,0,1 (one bit per cycle) -> `y` = 0 for all bits except the final 1, where `y` = 1 for that one cycle; state after that edge is S1.
- Hold `x` = 1 with `reset_n` = 0 over an edge while in S11 -> `y` = 0 throughout, state S0; after release, 1,1,0,1 needed for next `y` = 1.
- Sequence 1,1,0,1,1,0,1 with `OVERLAP`=1 -> `y` = 1 on bit 4 and bit 7 (two strobes); with `OVERLAP`=0 -> `y` = 1 on bit 4 only.
- Sequence 1,0,1,1,0,0,1 -> `y` never asserts; 1,1,1,1,0,1 -> `y` = 1 only on the last bit.
- Toggle `x` 0->1 mid-cycle while in S110 -> `y` follows `x` combinationally within the same cycle.
- With `MEALY_1101_DETECTOR_COUNT_EN`, `CNT_W`=2: drive 4 matches -> `match_count` = 1,2,3,3 (saturates); synchronous reset -> 0.
